fetch_unit: RTL

Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. It replaces the single-register IF stage with a PC generator, a variable-latency instruction-memory request/acknowledge handshake and a DEPTH-entry prefetch queue. It delivers {pc, instruction} pairs to ID through a valid/ready handshake. Exception/ERET redirects and branch/jump redirects flush the queue and discard in-flight fetches.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 34 +++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDrop
   } fetch_state_e;

   localparam int unsigned INST_NOP = 0;
   localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/fetch_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
interface fetch_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              redir_exc;
   logic [ADDR_W-1:0] exc_addr;
   logic              redir_br;
   logic [ADDR_W-1:0] br_addr;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              id_valid;
   logic              id_ready;
   logic [DATA_W-1:0] id_inst;
   logic [ADDR_W-1:0] id_pc;
   logic [ADDR_W-1:0] id_pc_next;
   logic [CNT_W-1:0]  q_count;

   modport master (
      input  redir_exc, exc_addr, redir_br, br_addr, imem_ack, imem_rdata, id_ready,
      output imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc_next, q_count
   );

   modport slave (
      output redir_exc, exc_addr, redir_br, br_addr, imem_ack, imem_rdata, id_ready,
      input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc_next, q_count
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO, head read combinationally from storage.
// Flush empties the queue and suppresses a same-cycle push; a same-cycle pop still advances.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && !flush;
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (flush) begin
         // Empty queue: write pointer realigns with the post-pop read pointer.
         wr_ptr_d = rd_ptr_d;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, imem req/ack handshake and prefetch queue
// delivering {pc, instruction} pairs to decode; redirects flush the queue.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic     clk,
   input logic     rst,
   fetch_if.master bus
);
   localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

   fetch_state_e             state_q, state_d;
   logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]        req_addr_q, req_addr_d;
   logic                     redir;
   logic [ADDR_W-1:0]        tgt;
   logic                     push, pop, head_valid;
   logic [CNT_W-1:0]         count, cnt_push;
   logic [ADDR_W+DATA_W-1:0] head;
   logic [ADDR_W-1:0]        id_pc;

   assign redir      = bus.redir_exc || bus.redir_br;
   assign tgt        = bus.redir_exc ? bus.exc_addr : bus.br_addr;
   assign head_valid = (count != '0);
   assign pop        = head_valid && bus.id_ready;
   // Occupancy after an edge that pushes.
   assign cnt_push   = count + CNT_W'(1) - CNT_W'(pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      push       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (redir) begin
               fetch_pc_d = tgt;
            end else if (count < FULL_CNT) begin
               state_d    = StBusy;
               req_addr_d = fetch_pc_q;
            end
         end
         StBusy: begin
            if (redir) begin
               fetch_pc_d = tgt;
               state_d    = bus.imem_ack ? StIdle : StDrop;
            end else if (bus.imem_ack) begin
               push       = 1'b1;
               fetch_pc_d = req_addr_q + STEP;
               if (cnt_push < FULL_CNT) begin
                  req_addr_d = req_addr_q + STEP;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StDrop: begin
            if (redir) begin
               fetch_pc_d = tgt;
            end
            if (bus.imem_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   fetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({req_addr_q, bus.imem_rdata}),
      .pop   (pop),
      .flush (redir),
      .count (count),
      .head  (head)
   );

   assign id_pc          = head_valid ? head[ADDR_W+DATA_W-1 -: ADDR_W] : '0;
   assign bus.imem_req   = (state_q != StIdle);
   assign bus.imem_addr  = req_addr_q;
   assign bus.id_valid   = head_valid;
   assign bus.id_pc      = id_pc;
   assign bus.id_pc_next = id_pc + STEP;
   assign bus.id_inst    = head_valid ? head[DATA_W-1:0] : DATA_W'(INST_NOP);
   assign bus.q_count    = count;

endmodule
